// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: FSM state encoding
// and the smallest bit period the receiver will run at.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and bit-value decision for the UART receiver.
// Macro UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around mid-bit.
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sample_tick,
  output logic                      sample_bit,
  output logic                      bit_end
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = 1;

  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] half;

  assign half    = prescale >> 1;
  assign bit_end = en && (edge_cnt == prescale - ONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
    end else if (en) begin
      edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic early;
  logic mid;

  // The third vote is the live line value at the decision edge.
  always_ff @(posedge CLK) begin
    if (en && (edge_cnt == half - ONE)) early <= rx_in;
    if (en && (edge_cnt == half))       mid   <= rx_in;
  end

  assign sample_tick = en && (edge_cnt == half + ONE);
  assign sample_bit  = (early & mid) | (early & rx_in) | (mid & rx_in);
`else
  assign sample_tick = en && (edge_cnt == half);
  assign sample_bit  = rx_in;
`endif

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing with
// parity and stop checking; frame result reported as one-cycle pulses.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_valid,
  output logic                      PAR_ERR,
  output logic                      STP_ERR,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_MIN = PRESCALE_WIDTH'(MIN_PRESCALE);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

  state_t state, state_nxt;

  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      stop2_q;
  logic [CNT_W-1:0]          bit_cnt;
  logic [CNT_W-1:0]          cnt_plus;
  logic                      par_flag;
  logic                      stp_flag;
  logic [DATA_WIDTH-1:0]     shift_q;

  logic start_entry, sample_tick, sample_bit, bit_end;
  logic data_done, last_stop, frame_done, stp_now, par_exp;

  assign busy        = (state != IDLE);
  assign start_entry = (state == IDLE) && !RX_IN;
  assign cnt_plus    = bit_cnt + CNT_W'(sample_tick);
  assign data_done   = (state == DATA) && bit_end && (cnt_plus == CNT_LAST);
  assign last_stop   = (bit_cnt == {{(CNT_W-1){1'b0}}, stop2_q});
  assign frame_done  = (state == STOP) && sample_tick && last_stop;
  assign stp_now     = stp_flag | ~sample_bit;
  assign par_exp     = (^shift_q) ^ par_typ_q;

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .en          (busy),
    .clear       (start_entry),
    .rx_in       (RX_IN),
    .prescale    (prescale_q),
    .sample_tick (sample_tick),
    .sample_bit  (sample_bit),
    .bit_end     (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!RX_IN) state_nxt = START;
      START: begin
        if (sample_tick && sample_bit) state_nxt = IDLE;
        else if (bit_end)              state_nxt = DATA;
      end
      DATA:   if (data_done) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_q <= PRESCALE_MIN;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      bit_cnt    <= '0;
      par_flag   <= 1'b0;
      stp_flag   <= 1'b0;
      P_DATA     <= '0;
      Data_valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      Data_valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      // Frame configuration is frozen for the whole frame at the start edge.
      if (start_entry) begin
        prescale_q <= (PRESCALE < PRESCALE_MIN) ? PRESCALE_MIN : PRESCALE;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        stop2_q    <= STOP2;
        bit_cnt    <= '0;
        par_flag   <= 1'b0;
        stp_flag   <= 1'b0;
      end
      case (state)
        DATA: bit_cnt <= data_done ? '0 : cnt_plus;
        PARITY: if (sample_tick && (sample_bit != par_exp)) par_flag <= 1'b1;
        STOP: begin
          if (sample_tick) begin
            stp_flag <= stp_now;
            if (last_stop) begin
              P_DATA     <= shift_q;
              Data_valid <= ~(par_flag | stp_now);
              PAR_ERR    <= par_flag;
              STP_ERR    <= stp_now;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if ((state == DATA) && sample_tick) shift_q <= {sample_bit, shift_q[DATA_WIDTH-1:1]};
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: table of frames plus hand-written
// sequences for start glitch, mid-frame reset and back-to-back frames.
module tb_uart_rx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rx = 1'b1;
  logic       rx7 = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;

  logic [7:0] p_data;
  logic       dv, pe, se, busy;
  logic [6:0] p_data7;
  logic       dv7, pe7, se7, busy7;

  always #5 CLK = ~CLK;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(rx), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(p_data), .Data_valid(dv),
    .PAR_ERR(pe), .STP_ERR(se), .busy(busy)
  );

  uart_rx_frame_ctrl #(.DATA_WIDTH(7), .PRESCALE_WIDTH(6)) dut7 (
    .CLK(CLK), .RST(RST), .RX_IN(rx7), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(p_data7), .Data_valid(dv7),
    .PAR_ERR(pe7), .STP_ERR(se7), .busy(busy7)
  );

  int checks = 0;
  int errors = 0;
  int n_dv = 0, n_pe = 0, n_se = 0, n_ovl = 0, n7 = 0;
  logic [7:0] last_data = 8'h00;
  logic [6:0] got7 [16];
  int b_dv, b_pe, b_se, b7;

  always @(negedge CLK) begin
    if (dv) n_dv++;
    if (pe) n_pe++;
    if (se) n_se++;
    if (dv && (pe || se)) n_ovl++;
    if (dv7 && (pe7 || se7)) n_ovl++;
    if (dv || pe || se) last_data = p_data;
    if (dv7) begin
      if (n7 < 16) got7[n7] = p_data7;
      n7++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input bit to7, input logic v, input int p, input int goff);
    for (int c = 0; c < p; c++) begin
      if (to7) rx7 = (c == goff) ? ~v : v;
      else     rx  = (c == goff) ? ~v : v;
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input bit to7, input int w, input logic [8:0] d, input int p,
                            input bit pen, input logic pb, input bit two, input logic s1,
                            input logic s2, input int gbit, input bit scr);
    drive_bit(to7, 1'b0, p, -1);
    if (scr) begin
      PRESCALE = 6'd40;
      PAR_EN   = 1'b1;
      STOP2    = 1'b1;
      PAR_TYP  = ~PAR_TYP;
    end
    for (int i = 0; i < w; i++) drive_bit(to7, d[i], p, (i == gbit) ? p / 2 + 1 : -1);
    if (pen) drive_bit(to7, pb, p, -1);
    drive_bit(to7, s1, p, -1);
    if (two) drive_bit(to7, s2, p, -1);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [5:0] pin;
    int         pbit;
    bit         pen;
    bit         ptyp;
    logic       pb;
    bit         two;
    logic       s1;
    logic       s2;
    int         gbit;
    bit         scr;
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
    logic [7:0] exp_data;
  } vec_t;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [7:0] GLITCH_EXP = 8'hA5;
`else
  localparam logic [7:0] GLITCH_EXP = 8'hA4;
`endif

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{"a5_p16",       8'hA5, 6'd16, 16, 0, 0, 1'b0, 0, 1'b1, 1'b1, -1, 0, 1, 0, 0, 8'hA5};
    vecs[1]  = '{"par_bad",      8'h3C, 6'd8,  8,  1, 1, 1'b0, 0, 1'b1, 1'b1, -1, 0, 0, 1, 0, 8'h3C};
    vecs[2]  = '{"par_odd_ok",   8'h3C, 6'd8,  8,  1, 1, 1'b1, 0, 1'b1, 1'b1, -1, 0, 1, 0, 0, 8'h3C};
    vecs[3]  = '{"par_even_ok",  8'h83, 6'd8,  8,  1, 0, 1'b1, 0, 1'b1, 1'b1, -1, 0, 1, 0, 0, 8'h83};
    vecs[4]  = '{"stop2_ok",     8'h0F, 6'd8,  8,  0, 0, 1'b0, 1, 1'b1, 1'b1, -1, 0, 1, 0, 0, 8'h0F};
    vecs[5]  = '{"stop2_bad",    8'h5A, 6'd16, 16, 0, 0, 1'b0, 1, 1'b1, 1'b0, -1, 0, 0, 0, 1, 8'h5A};
    vecs[6]  = '{"clamp",        8'h96, 6'd2,  4,  0, 0, 1'b0, 0, 1'b1, 1'b1, -1, 0, 1, 0, 0, 8'h96};
    vecs[7]  = '{"stop1_bad",    8'h00, 6'd8,  8,  0, 0, 1'b0, 0, 1'b0, 1'b1, -1, 0, 0, 0, 1, 8'h00};
    vecs[8]  = '{"par_stop_bad", 8'hC3, 6'd8,  8,  1, 0, 1'b1, 0, 1'b0, 1'b1, -1, 0, 0, 1, 1, 8'hC3};
    vecs[9]  = '{"cfg_freeze",   8'h33, 6'd8,  8,  0, 0, 1'b0, 0, 1'b1, 1'b1, -1, 1, 1, 0, 0, 8'h33};
    vecs[10] = '{"mid_glitch",   8'hA5, 6'd16, 16, 0, 0, 1'b0, 0, 1'b1, 1'b1, 0,  0, 1, 0, 0, GLITCH_EXP};

    // Reset state
    #3 RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_p_data", p_data, 0);
    check("rst_valid", dv, 0);
    check("rst_par_err", pe, 0);
    check("rst_stp_err", se, 0);
    check("rst_busy", busy, 0);
    @(negedge CLK) RST = 1'b1;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      PRESCALE = vecs[i].pin;
      PAR_EN   = vecs[i].pen;
      PAR_TYP  = vecs[i].ptyp;
      STOP2    = vecs[i].two;
      b_dv = n_dv; b_pe = n_pe; b_se = n_se;
      send_frame(0, 8, {1'b0, vecs[i].data}, vecs[i].pbit, vecs[i].pen, vecs[i].pb,
                 vecs[i].two, vecs[i].s1, vecs[i].s2, vecs[i].gbit, vecs[i].scr);
      rx = 1'b1;
      repeat (2 * vecs[i].pbit + 4) @(negedge CLK);
      #1;
      check({vecs[i].name, "_valid"}, n_dv - b_dv, vecs[i].exp_dv);
      check({vecs[i].name, "_par_err"}, n_pe - b_pe, vecs[i].exp_pe);
      check({vecs[i].name, "_stp_err"}, n_se - b_se, vecs[i].exp_se);
      check({vecs[i].name, "_data"}, last_data, vecs[i].exp_data);
    end

    // Short low pulse on the line: START then back to IDLE without output
    @(negedge CLK);
    PRESCALE = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b0;
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    rx = 1'b0;
    @(negedge CLK);
    check("glitch_busy_high", busy, 1);
    @(negedge CLK);
    @(negedge CLK) rx = 1'b1;
    repeat (14) @(negedge CLK);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_pulse", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);

    // Reset in the middle of a frame
    @(negedge CLK);
    PRESCALE = 6'd8;
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    drive_bit(0, 1'b0, 8, -1);
    drive_bit(0, 1'b1, 8, -1);
    drive_bit(0, 1'b0, 4, -1);
    #2 RST = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_p_data", p_data, 0);
    @(negedge CLK) rx = 1'b1;
    @(negedge CLK) RST = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    check("midrst_no_pulse", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);
    @(negedge CLK);
    b_dv = n_dv;
    send_frame(0, 8, 9'h06B, 8, 0, 1'b0, 0, 1'b1, 1'b1, -1, 0);
    rx = 1'b1;
    repeat (20) @(negedge CLK);
    #1;
    check("after_rst_valid", n_dv - b_dv, 1);
    check("after_rst_data", last_data, 8'h6B);

    // Back-to-back 7-bit frames with no idle gap
    @(negedge CLK);
    PRESCALE = 6'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    b7 = n7;
    send_frame(1, 7, 9'h055, 8, 0, 1'b0, 0, 1'b1, 1'b1, -1, 0);
    send_frame(1, 7, 9'h02A, 8, 0, 1'b0, 0, 1'b1, 1'b1, -1, 0);
    rx7 = 1'b1;
    repeat (20) @(negedge CLK);
    #1;
    check("b2b_count", n7 - b7, 2);
    check("b2b_first", got7[b7], 7'h55);
    check("b2b_second", got7[b7 + 1], 7'h2A);
    check("no_overlap", n_ovl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
